// File: rtl/vlg_pulse_counter.sv
// Gated pulse counter: counts synchronized rising edges of i_pulse while i_en is high.
// Each new enable window clears the count; the last window's count is held afterwards.
module vlg_pulse_counter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_pulse,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_pulse_cnt
);

  logic [SYNC_STAGES-1:0] p_sh;
  logic [SYNC_STAGES-1:0] en_sh;
  logic                   p_dly;
  logic                   en_dly;
  logic                   p_sync;
  logic                   en_sync;
  logic                   p_rise;
  logic                   en_rise;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nxt;

  assign p_sync  = p_sh[SYNC_STAGES-1];
  assign en_sync = en_sh[SYNC_STAGES-1];
  assign p_rise  = p_sync & ~p_dly;
  assign en_rise = en_sync & ~en_dly;

  // rst_n is active-high here; both chains share one depth so pulse/enable stay aligned.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      p_sh   <= '0;
      en_sh  <= '0;
      p_dly  <= 1'b0;
      en_dly <= 1'b0;
    end else begin
      p_sh   <= {p_sh[SYNC_STAGES-2:0], i_pulse};
      en_sh  <= {en_sh[SYNC_STAGES-2:0], i_en};
      p_dly  <= p_sync;
      en_dly <= en_sync;
    end
  end

  always_comb begin
    cnt_nxt = cnt;
    if (en_rise && p_rise) begin
      cnt_nxt = CNT_W'(1);
    end else if (en_rise) begin
      cnt_nxt = '0;
    end else if (en_sync && p_rise) begin
      // Saturate at all-ones instead of wrapping.
      if (cnt != {CNT_W{1'b1}}) cnt_nxt = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) cnt <= '0;
    else       cnt <= cnt_nxt;
  end

  assign o_pulse_cnt = cnt;

endmodule

// File: tb/tb_vlg_pulse_counter.sv
// Directed bench for vlg_pulse_counter: a default-width instance and a CNT_W=4
// instance for saturation, checked against hand-computed counts.
module tb_vlg_pulse_counter;

  logic        clk;
  logic        rst_n;
  logic        pulse;
  logic        en;
  logic [15:0] cnt;

  logic        rst4;
  logic        pulse4;
  logic        en4;
  logic [3:0]  cnt4;

  int n_tests;
  int n_fail;

  vlg_pulse_counter #(.CNT_W(16), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_pulse     (pulse),
    .i_en        (en),
    .o_pulse_cnt (cnt)
  );

  vlg_pulse_counter #(.CNT_W(4), .SYNC_STAGES(2)) dut4 (
    .clk         (clk),
    .rst_n       (rst4),
    .i_pulse     (pulse4),
    .i_en        (en4),
    .o_pulse_cnt (cnt4)
  );

  // Clock / reset block: 100 MHz
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // n pulses of 300 ns high / 500 ns low; sel picks the instance
  task automatic drive_pulses(input int n, input bit sel);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sel) pulse4 = 1'b1; else pulse = 1'b1;
      wait_cyc(30);
      if (sel) pulse4 = 1'b0; else pulse = 1'b0;
      wait_cyc(50);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b1; pulse = 1'b0; en = 1'b0;
    rst4  = 1'b1; pulse4 = 1'b0; en4 = 1'b0;

    // Reset held while inputs toggle
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      en = ~en;
      pulse = (i % 3) == 0;
      #1 check("reset_hold", cnt, 16'd0);
    end
    @(negedge clk);
    en = 1'b0; pulse = 1'b0;
    wait_cyc(2);
    rst_n = 1'b0;
    wait_cyc(5);
    check("after_release", cnt, 16'd0);

    // Window of 50
    en = 1'b1;
    wait_cyc(10);
    check("win1_open", cnt, 16'd0);
    drive_pulses(50, 1'b0);
    check("win1_count", cnt, 16'd50);
    en = 1'b0;
    wait_cyc(100);
    check("win1_hold", cnt, 16'd50);

    // New window of 69 clears old result first
    en = 1'b1;
    wait_cyc(10);
    check("win2_clear", cnt, 16'd0);
    drive_pulses(69, 1'b0);
    en = 1'b0;
    wait_cyc(10);
    check("win2_count", cnt, 16'd69);

    // Pulses outside window ignored
    drive_pulses(15, 1'b0);
    check("closed_ignore", cnt, 16'd69);

    // Latency: steps exactly on the 3rd edge after first sampled-high edge
    en = 1'b1;
    wait_cyc(10);
    check("lat_clear", cnt, 16'd0);
    pulse = 1'b1;
    @(posedge clk); #1 check("lat_edge1", cnt, 16'd0);
    @(posedge clk); #1 check("lat_edge2", cnt, 16'd0);
    @(posedge clk); #1 check("lat_edge3", cnt, 16'd1);
    wait_cyc(30);
    pulse = 1'b0;
    wait_cyc(10);
    en = 1'b0;
    wait_cyc(10);

    // Pulse already high when window opens is not counted
    pulse = 1'b1;
    wait_cyc(10);
    en = 1'b1;
    wait_cyc(10);
    check("pre_high_skip", cnt, 16'd0);
    pulse = 1'b0;
    wait_cyc(10);
    pulse = 1'b1;
    wait_cyc(10);
    check("pre_high_next", cnt, 16'd1);
    pulse = 1'b0;
    en = 1'b0;
    wait_cyc(10);
    check("pre_high_hold", cnt, 16'd1);

    // Enable and pulse rise together: count starts at 1
    @(negedge clk);
    en = 1'b1; pulse = 1'b1;
    wait_cyc(10);
    check("joint_rise", cnt, 16'd1);
    pulse = 1'b0;
    wait_cyc(10);
    drive_pulses(2, 1'b0);
    check("joint_more", cnt, 16'd3);

    // Enable falls in same cycle as pulse edge: not counted
    @(negedge clk);
    en = 1'b0; pulse = 1'b1;
    wait_cyc(10);
    check("fall_same_cyc", cnt, 16'd3);
    pulse = 1'b0;
    wait_cyc(5);

    // Saturation on CNT_W=4 instance
    rst4 = 1'b0;
    wait_cyc(3);
    check("w4_reset", {12'd0, cnt4}, 16'd0);
    en4 = 1'b1;
    wait_cyc(10);
    drive_pulses(14, 1'b1);
    check("w4_14", {12'd0, cnt4}, 16'd14);
    drive_pulses(6, 1'b1);
    check("w4_saturate", {12'd0, cnt4}, 16'd15);

    // Reset mid-window is immediate; window continues with en still high
    @(negedge clk);
    rst4 = 1'b1;
    #1 check("w4_mid_reset", {12'd0, cnt4}, 16'd0);
    wait_cyc(3);
    rst4 = 1'b0;
    wait_cyc(10);
    check("w4_post_reset", {12'd0, cnt4}, 16'd0);
    drive_pulses(3, 1'b1);
    check("w4_recount", {12'd0, cnt4}, 16'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
